// File: rtl/tcp_tx_arbiter.sv
// ============================================================================
// tcp_tx_arbiter
// ----------------------------------------------------------------------------
// Packet-granular round-robin arbiter. Merges N_PORTS per-connection transmit
// packet FIFOs (64-bit AXI-Stream style) into one egress stream toward the MAC.
// A grant is taken in IDLE (one arbitration cycle per packet) and held from
// the first beat of a packet through its last beat, so packets never
// interleave. While a port is granted its beat fields pass straight through
// combinationally to the egress side.
//
// Optional feature (macro TCP_ARB_WATCHDOG_EN):
//   Adds parameter TIMEOUT and output watchdog_hit_o. A granted source that
//   leaves its valid low for TIMEOUT cycles is cut off with one synthetic
//   terminating beat (last=1, user=1, keep=0, data=0) that consumes nothing
//   from the source. Without the macro a stalled source keeps the grant.
//
// Parameters:
//   N_PORTS    number of requesting FIFOs (2..8)
//   CNT_WIDTH  width of the forwarded-packet counter
//   TIMEOUT    watchdog stall limit in cycles (watchdog build only)
//
// Ports:
//   clk_i           system clock, rising edge
//   rst_ni          asynchronous active-low reset
//   in_valid_i      per-port beat valid
//   in_ready_o      per-port beat ready
//   in_data_i       per-port data, port i at [64i+63:64i]
//   in_keep_i       per-port byte keep, port i at [8i+7:8i]
//   in_last_i       per-port end of packet
//   in_user_i       per-port error flag
//   out_valid_o     egress valid
//   out_ready_i     egress ready
//   out_data_o      egress data
//   out_keep_o      egress keep
//   out_last_o      egress last
//   out_user_o      egress error flag (passed through unchanged)
//   grant_o         one-hot current grant, zero while idle
//   packet_count_o  packets forwarded since reset, wraps
//   watchdog_hit_o  sticky watchdog flag (watchdog build only)
// ============================================================================
module tcp_tx_arbiter #(
    parameter int N_PORTS   = 4,
    parameter int CNT_WIDTH = 16
`ifdef TCP_ARB_WATCHDOG_EN
    ,
    parameter int TIMEOUT   = 255
`endif
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [N_PORTS-1:0]      in_valid_i,
    output logic [N_PORTS-1:0]      in_ready_o,
    input  logic [64*N_PORTS-1:0]   in_data_i,
    input  logic [8*N_PORTS-1:0]    in_keep_i,
    input  logic [N_PORTS-1:0]      in_last_i,
    input  logic [N_PORTS-1:0]      in_user_i,
    output logic                    out_valid_o,
    input  logic                    out_ready_i,
    output logic [63:0]             out_data_o,
    output logic [7:0]              out_keep_o,
    output logic                    out_last_o,
    output logic                    out_user_o,
    output logic [N_PORTS-1:0]      grant_o,
    output logic [CNT_WIDTH-1:0]    packet_count_o
`ifdef TCP_ARB_WATCHDOG_EN
    ,
    output logic                    watchdog_hit_o
`endif
);

    localparam int                 IDX_W    = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
    localparam int                 PW       = IDX_W + 1;
    localparam logic [PW-1:0]      N_PW     = PW'(N_PORTS);
    localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(N_PORTS - 1);
    localparam logic [N_PORTS-1:0] ONE_HOT0 = N_PORTS'(1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_XFER = 1'b1
    } state_e;

    state_e                 state_q;
    logic [N_PORTS-1:0]     grant_q;
    logic [IDX_W-1:0]       gidx_q;      // binary index of the granted port
    logic [IDX_W-1:0]       rr_ptr_q;
    logic [IDX_W-1:0]       rr_ptr_d;
    logic [CNT_WIDTH-1:0]   pkt_cnt_q;
    logic [CNT_WIDTH-1:0]   pkt_cnt_d;

    logic                   scan_found;
    logic [IDX_W-1:0]       scan_idx;
    logic                   beat_acc;
    logic                   pkt_end;

    // Per-port views of the flat data/keep buses.
    logic [63:0]            port_data [N_PORTS];
    logic [7:0]             port_keep [N_PORTS];

    generate
        for (genvar gi = 0; gi < N_PORTS; gi++) begin : g_unpack
            assign port_data[gi] = in_data_i[64*gi +: 64];
            assign port_keep[gi] = in_keep_i[8*gi +: 8];
        end
    endgenerate

`ifdef TCP_ARB_WATCHDOG_EN
    localparam int SW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    logic [SW-1:0]  stall_q;
    logic [SW-1:0]  stall_d;
    logic           wd_hit_q;
    logic           wd_fire;

    // Once the limit is reached the synthetic beat is held until accepted,
    // even if the source comes back, so the egress handshake stays stable.
    assign wd_fire = (state_q == S_XFER) && (stall_q == SW'(TIMEOUT));

    always_comb begin
        stall_d = stall_q;
        if (beat_acc) begin
            stall_d = '0;
        end else if (!in_valid_i[gidx_q] && !wd_fire) begin
            stall_d = stall_q + SW'(1);
        end
    end

    assign watchdog_hit_o = wd_hit_q;
`endif

    // Round-robin scan: first requesting port at or after rr_ptr_q, modulo
    // N_PORTS. Walking the offsets from high to low lets the lowest offset win.
    always_comb begin
        logic [PW-1:0] p_wide;
        scan_found = 1'b0;
        scan_idx   = '0;
        p_wide     = '0;
        for (int k = N_PORTS - 1; k >= 0; k--) begin
            p_wide = {1'b0, rr_ptr_q} + PW'(k);
            if (p_wide >= N_PW) begin
                p_wide = p_wide - N_PW;
            end
            if (in_valid_i[p_wide[IDX_W-1:0]]) begin
                scan_found = 1'b1;
                scan_idx   = p_wide[IDX_W-1:0];
            end
        end
    end

    // Egress pass-through of the granted port. In IDLE nothing is offered and
    // nothing is consumed; grant_q is zero there, which also keeps in_ready low.
    always_comb begin
        out_valid_o = 1'b0;
        out_data_o  = '0;
        out_keep_o  = '0;
        out_last_o  = 1'b0;
        out_user_o  = 1'b0;
        in_ready_o  = '0;
        if (state_q == S_XFER) begin
            out_valid_o = in_valid_i[gidx_q];
            out_data_o  = port_data[gidx_q];
            out_keep_o  = port_keep[gidx_q];
            out_last_o  = in_last_i[gidx_q];
            out_user_o  = in_user_i[gidx_q];
            in_ready_o  = grant_q & {N_PORTS{out_ready_i}};
`ifdef TCP_ARB_WATCHDOG_EN
            if (wd_fire) begin
                out_valid_o = 1'b1;
                out_data_o  = '0;
                out_keep_o  = '0;
                out_last_o  = 1'b1;
                out_user_o  = 1'b1;
                in_ready_o  = '0;
            end
`endif
        end
    end

    assign beat_acc = out_valid_o && out_ready_i;
    assign pkt_end  = beat_acc && out_last_o;

    // Next round-robin start is the port after the one just served.
    assign rr_ptr_d  = (gidx_q == LAST_IDX) ? '0 : gidx_q + IDX_W'(1);
    assign pkt_cnt_d = pkt_cnt_q + CNT_WIDTH'(1);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= S_IDLE;
            grant_q   <= '0;
            gidx_q    <= '0;
            rr_ptr_q  <= '0;
            pkt_cnt_q <= '0;
`ifdef TCP_ARB_WATCHDOG_EN
            stall_q   <= '0;
            wd_hit_q  <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (scan_found) begin
                        state_q <= S_XFER;
                        grant_q <= ONE_HOT0 << scan_idx;
                        gidx_q  <= scan_idx;
`ifdef TCP_ARB_WATCHDOG_EN
                        stall_q <= '0;
`endif
                    end
                end
                S_XFER: begin
                    if (pkt_end) begin
                        state_q  <= S_IDLE;
                        grant_q  <= '0;
                        rr_ptr_q <= rr_ptr_d;
`ifdef TCP_ARB_WATCHDOG_EN
                        // A watchdog-terminated packet is flagged, not counted.
                        if (wd_fire) begin
                            wd_hit_q <= 1'b1;
                        end else begin
                            pkt_cnt_q <= pkt_cnt_d;
                        end
`else
                        pkt_cnt_q <= pkt_cnt_d;
`endif
                    end
`ifdef TCP_ARB_WATCHDOG_EN
                    stall_q <= stall_d;
`endif
                end
                default: begin
                    state_q <= S_IDLE;
                    grant_q <= '0;
                end
            endcase
        end
    end

    assign grant_o        = grant_q;
    assign packet_count_o = pkt_cnt_q;

endmodule

// File: tb/tb_tcp_tx_arbiter.sv
`timescale 1ns/1ps
module tb_tcp_tx_arbiter;

    localparam int N  = 4;
    localparam int CW = 16;
    localparam int TO = 8;
`ifdef TCP_ARB_WATCHDOG_EN
    localparam bit WD        = 1'b1;
    localparam int STALL_LEN = TO - 3;
`else
    localparam bit WD        = 1'b0;
    localparam int STALL_LEN = 10;
`endif

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    in_valid, in_ready, in_last, in_user;
    logic [64*N-1:0] in_data;
    logic [8*N-1:0]  in_keep;
    logic            out_valid, out_ready, out_last, out_user;
    logic [63:0]     out_data;
    logic [7:0]      out_keep;
    logic [N-1:0]    grant;
    logic [CW-1:0]   pkt_cnt;
`ifdef TCP_ARB_WATCHDOG_EN
    logic            wd_hit;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    tcp_tx_arbiter #(
        .N_PORTS   (N),
        .CNT_WIDTH (CW)
`ifdef TCP_ARB_WATCHDOG_EN
        ,
        .TIMEOUT   (TO)
`endif
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .in_valid_i     (in_valid),
        .in_ready_o     (in_ready),
        .in_data_i      (in_data),
        .in_keep_i      (in_keep),
        .in_last_i      (in_last),
        .in_user_i      (in_user),
        .out_valid_o    (out_valid),
        .out_ready_i    (out_ready),
        .out_data_o     (out_data),
        .out_keep_o     (out_keep),
        .out_last_o     (out_last),
        .out_user_o     (out_user),
        .grant_o        (grant),
        .packet_count_o (pkt_cnt)
`ifdef TCP_ARB_WATCHDOG_EN
        ,
        .watchdog_hit_o (wd_hit)
`endif
    );

    typedef struct {
        logic [N-1:0] v;    // in_valid
        logic [N-1:0] l;    // in_last
        logic         r;    // out_ready
        logic [N-1:0] g;    // expected grant
        logic         ov;   // expected out_valid
        logic         ol;   // expected out_last
        logic [N-1:0] ir;   // expected in_ready
        int           cnt;  // expected packet count
    } vec_t;

    vec_t tbl [15];

    // Reference model state (transaction level: idle/busy, owner, pointer).
    int              m_busy, m_port, m_ptr, m_stall, m_wd;
    logic [CW-1:0]   m_cnt;
    logic            e_ov, e_last, e_user, fire;
    logic [N-1:0]    e_g, e_ir;
    logic [63:0]     e_data;
    logic [7:0]      e_keep;
    int              n, cyc, b, st, seen, gi, p;

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int idx_of(input logic [N-1:0] oh);
        for (int i = 0; i < N; i++) if (oh[i]) return i;
        return 0;
    endfunction

    task automatic do_reset();
        in_valid  = '0;
        in_last   = '0;
        out_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not finish, got running, expected done");
        $fatal(1, "timeout");
    end

    initial begin
        // valid,  last,   rdy | grant,  ov, ol, in_ready, count
        tbl[0]  = '{4'b0101, 4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0, 4'b0000, 0};
        tbl[1]  = '{4'b0101, 4'b0000, 1'b1, 4'b0001, 1'b1, 1'b0, 4'b0001, 0};
        tbl[2]  = '{4'b0101, 4'b0000, 1'b1, 4'b0001, 1'b1, 1'b0, 4'b0001, 0};
        tbl[3]  = '{4'b0101, 4'b0001, 1'b1, 4'b0001, 1'b1, 1'b1, 4'b0001, 0};
        tbl[4]  = '{4'b0100, 4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0, 4'b0000, 1};
        tbl[5]  = '{4'b0100, 4'b0000, 1'b1, 4'b0100, 1'b1, 1'b0, 4'b0100, 1};
        tbl[6]  = '{4'b0100, 4'b0000, 1'b1, 4'b0100, 1'b1, 1'b0, 4'b0100, 1};
        tbl[7]  = '{4'b0100, 4'b0100, 1'b1, 4'b0100, 1'b1, 1'b1, 4'b0100, 1};
        tbl[8]  = '{4'b0010, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000, 2};
        tbl[9]  = '{4'b1011, 4'b0000, 1'b0, 4'b0010, 1'b1, 1'b0, 4'b0000, 2};
        tbl[10] = '{4'b1001, 4'b0000, 1'b1, 4'b0010, 1'b0, 1'b0, 4'b0010, 2};
        tbl[11] = '{4'b1011, 4'b0010, 1'b1, 4'b0010, 1'b1, 1'b1, 4'b0010, 2};
        tbl[12] = '{4'b1001, 4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0, 4'b0000, 3};
        tbl[13] = '{4'b1001, 4'b1000, 1'b1, 4'b1000, 1'b1, 1'b1, 4'b1000, 3};
        tbl[14] = '{4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0, 4'b0000, 4};

        for (int i = 0; i < N; i++) begin
            in_data[64*i +: 64] = {32'hA5A5_0000, 32'(i)};
            in_keep[8*i +: 8]   = 8'h80 | 8'(i);
        end
        in_user   = 4'b0100;
        in_valid  = 4'b1111;
        in_last   = 4'b0000;
        out_ready = 1'b1;
        rst_n     = 1'b1;
        #2 rst_n  = 1'b0;

        // ---------------- reset state ----------------
        repeat (3) @(negedge clk);
        check("rst_grant", grant, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_count", pkt_cnt, 0);
        in_valid = '0;
        rst_n    = 1'b1;
        tick();

        // ---------------- table vectors ----------------
        for (int r = 0; r < 15; r++) begin
            in_valid  = tbl[r].v;
            in_last   = tbl[r].l;
            out_ready = tbl[r].r;
            @(negedge clk);
            $display("[TB] vec %0d grant=%b ov=%b cnt=%0d", r, grant, out_valid, pkt_cnt);
            check($sformatf("vec%0d_grant", r), grant, tbl[r].g);
            check($sformatf("vec%0d_ov", r), out_valid, tbl[r].ov);
            check($sformatf("vec%0d_in_ready", r), in_ready, tbl[r].ir);
            check($sformatf("vec%0d_count", r), pkt_cnt, tbl[r].cnt);
            if (tbl[r].ov) begin
                gi = idx_of(tbl[r].g);
                check($sformatf("vec%0d_last", r), out_last, tbl[r].ol);
                check($sformatf("vec%0d_data", r), {out_data, out_keep, out_user},
                      {32'hA5A5_0000, 32'(gi), 8'h80 | 8'(gi), gi == 2});
            end
            tick();
        end

        // ---------------- fairness: 16 single-beat packets ----------------
        in_valid = 4'hF; in_last = 4'hF; out_ready = 1'b1;
        n = 0; cyc = 0;
        while (n < 16 && cyc < 80) begin
            @(negedge clk);
            cyc++;
            if (out_valid && out_ready) begin
                $display("[TB] fair pkt %0d from port %0d at cycle %0d", n, idx_of(grant), cyc);
                check($sformatf("fair_src%0d", n), idx_of(grant), n % N);
                n++;
            end
            tick();
        end
        check("fair_pkts", n, 16);
        check("fair_cycles", cyc, 32);
        in_valid = '0; in_last = '0;
        @(negedge clk);
        check("fair_count", pkt_cnt, 20);
        tick();

        // ---------------- port 1 five beats, toggling backpressure ----------------
        in_valid = 4'b0010; b = 0; cyc = 0;
        while (b < 5 && cyc < 40) begin
            out_ready = (cyc % 2 == 0);
            in_data[64 +: 64] = 64'h1111_0000_0000_0000 + 64'(b);
            in_last[1] = (b == 4);
            @(negedge clk);
            if (grant == 4'b0010)
                check($sformatf("bp_ready%0d", cyc), in_ready, {2'b00, out_ready, 1'b0});
            if (in_ready[1]) begin
                $display("[TB] bp beat %0d data=%h", b, out_data);
                check($sformatf("bp_beat%0d", b), {out_valid, out_last, out_data},
                      {1'b1, b == 4, 64'h1111_0000_0000_0000 + 64'(b)});
                b++;
            end
            cyc++;
            tick();
        end
        check("bp_beats", b, 5);
        in_valid = '0; in_last = '0; out_ready = 1'b1;
        @(negedge clk);
        check("bp_count", pkt_cnt, 21);
        tick();

        // ---------------- port 3 stalls mid-packet while port 0 requests ----------------
        b = 0; st = 0; cyc = 0;
        in_data[63:0] = 64'h0000_0000_0000_00F0;
        in_last[0]    = 1'b1;
        while (b < 4 && cyc < 60) begin
            in_valid[0] = 1'b1;
            in_valid[3] = !(b == 2 && st < STALL_LEN);
            in_last[3]  = (b == 3);
            in_data[192 +: 64] = 64'h3333_0000_0000_0000 + 64'(b);
            @(negedge clk);
            if (cyc > 0) check($sformatf("st_grant%0d", cyc), grant, 4'b1000);
            if (!in_valid[3]) begin
                check($sformatf("st_noout%0d", st), out_valid, 0);
                st++;
            end
            if (in_valid[3] && in_ready[3]) begin
                $display("[TB] stall-test beat %0d data=%h", b, out_data);
                check($sformatf("st_beat%0d", b), {out_valid, out_data},
                      {1'b1, 64'h3333_0000_0000_0000 + 64'(b)});
                b++;
            end
            cyc++;
            tick();
        end
        check("st_beats", b, 4);
        check("st_stalls", st, STALL_LEN);
        in_valid[3] = 1'b0; in_last[3] = 1'b0;
        @(negedge clk);
        check("st_idle", grant, 0);
        tick();
        @(negedge clk);
        check("st_next_grant", {grant, out_valid, out_data}, {4'b0001, 1'b1, 64'h0000_0000_0000_00F0});
        tick();
        in_valid = '0; in_last = '0;
        @(negedge clk);
        check("st_count", pkt_cnt, 23);
        tick();

        // ---------------- asynchronous reset mid-packet on port 2 ----------------
        in_valid = 4'b0100; in_last = '0; out_ready = 1'b1;
        tick();
        tick();
        @(negedge clk);
        check("ar_pre", {grant, out_valid}, {4'b0100, 1'b1});
        #1 rst_n = 1'b0;
        in_valid = 4'hF;
        #1;
        check("ar_out_valid", out_valid, 0);
        check("ar_grant", grant, 0);
        check("ar_count", pkt_cnt, 0);
        check("ar_in_ready", in_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("ar_restart_port0", grant, 4'b0001);
        tick();

        // ---------------- randomized run against the reference model ----------------
        do_reset();
        m_busy = 0; m_port = 0; m_ptr = 0; m_stall = 0; m_wd = 0; m_cnt = '0;
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < N; i++) begin
                in_valid[i] = ($urandom_range(0, 9) < 7);
                in_last[i]  = ($urandom_range(0, 9) < 3);
                in_user[i]  = 1'($urandom_range(0, 1));
                in_data[64*i +: 64] = {$urandom, $urandom};
                in_keep[8*i +: 8]   = 8'($urandom);
            end
            out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            e_ov = 1'b0; e_ir = '0; e_g = '0; e_data = '0; e_keep = '0;
            e_last = 1'b0; e_user = 1'b0; fire = 1'b0;
            if (m_busy != 0) begin
                e_g  = 4'b0001 << m_port;
                fire = WD && (m_stall >= TO);
                if (fire) begin
                    e_ov = 1'b1; e_last = 1'b1; e_user = 1'b1;
                end else begin
                    e_ov   = in_valid[m_port];
                    e_data = in_data[64*m_port +: 64];
                    e_keep = in_keep[8*m_port +: 8];
                    e_last = in_last[m_port];
                    e_user = in_user[m_port];
                    e_ir   = e_g & {N{out_ready}};
                end
            end
            check($sformatf("rnd%0d_ctrl", c), {out_valid, grant, in_ready, pkt_cnt},
                  {e_ov, e_g, e_ir, m_cnt});
            if (e_ov)
                check($sformatf("rnd%0d_beat", c), {out_data, out_keep, out_last, out_user},
                      {e_data, e_keep, e_last, e_user});
`ifdef TCP_ARB_WATCHDOG_EN
            check($sformatf("rnd%0d_wd", c), wd_hit, m_wd);
`endif
            if (m_busy != 0) begin
                if (e_ov && out_ready) begin
                    m_stall = 0;
                    if (e_last) begin
                        m_busy = 0;
                        m_ptr  = (m_port + 1) % N;
                        if (fire) m_wd = 1;
                        else      m_cnt = m_cnt + 1'b1;
                    end
                end else if (!in_valid[m_port] && !fire) begin
                    m_stall++;
                end
            end else begin
                for (int k = 0; k < N; k++) begin
                    p = (m_ptr + k) % N;
                    if (in_valid[p]) begin
                        m_busy = 1; m_port = p; m_stall = 0;
                        break;
                    end
                end
            end
            tick();
        end
        $display("[TB] random run: %0d packets forwarded", m_cnt);

`ifdef TCP_ARB_WATCHDOG_EN
        // ---------------- watchdog: port 1 stalls after its first beat ----------------
        do_reset();
        in_valid = 4'b0010; in_last = '0; out_ready = 1'b1;
        in_data[64 +: 64] = 64'h5555;
        tick();
        @(negedge clk);
        check("wd_first", {out_valid, out_data}, {1'b1, 64'h5555});
        tick();
        in_valid = '0;
        n = 0; seen = 0;
        while (n < 40) begin
            @(negedge clk);
            if (out_valid) begin
                seen = 1;
                break;
            end
            n++;
            tick();
        end
        check("wd_seen", seen, 1);
        check("wd_wait", n, TO);
        check("wd_beat", {out_valid, out_last, out_user, out_keep, out_data, in_ready},
              {1'b1, 1'b1, 1'b1, 8'h00, 64'h0, 4'h0});
        check("wd_hit_pre", wd_hit, 0);
        tick();
        in_valid = 4'b0110;
        @(negedge clk);
        check("wd_hit", wd_hit, 1);
        check("wd_count", pkt_cnt, 0);
        check("wd_idle", grant, 0);
        tick();
        @(negedge clk);
        check("wd_next_port2", grant, 4'b0100);
        tick();
        in_valid = '0;
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
